// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings: ALU/writeback selects, x0 index and the ID/EX bubble control word.
package rv32i_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_LUI  = 4'd10
   } alu_sel_e;

   typedef enum logic [1:0] {
      WB_MEM = 2'd0,
      WB_ALU = 2'd1,
      WB_PC4 = 2'd2,
      WB_IMM = 2'd3
   } wb_sel_e;

   localparam logic [4:0] REG_X0 = 5'd0;

   typedef struct packed {
      logic       valid;
      logic       reg_wen;
      logic       mem_read;
      logic       mem_rw;
      logic [3:0] alu_sel;
      logic [1:0] wb_sel;
   } ctrl_t;

   // A bubble must never write, access memory or look valid to forwarding.
   localparam ctrl_t CTRL_BUBBLE = '{valid: 1'b0, reg_wen: 1'b0, mem_read: 1'b0,
                                     mem_rw: 1'b0, alu_sel: 4'd0, wb_sel: 2'd0};

endpackage

// File: rtl/loaduse_detect.sv
// Combinational load-use hazard compare between the load in EX and the instruction in ID.
module loaduse_detect
   import rv32i_pkg::*;
(
   input  logic       valid_id_i,
   input  logic       valid_ex_i,
   input  logic       mem_read_ex_i,
   input  logic       reg_wen_ex_i,
   input  logic [4:0] rd_ex_i,
   input  logic [4:0] rs1_id_i,
   input  logic [4:0] rs2_id_i,
   output logic       load_use_o
);

   logic rd_match_s;

   assign rd_match_s = (rd_ex_i == rs1_id_i) | (rd_ex_i == rs2_id_i);

   // Loads targeting x0 produce nothing to wait for.
   assign load_use_o = valid_id_i & valid_ex_i & mem_read_ex_i & reg_wen_ex_i
                     & (rd_ex_i != REG_X0) & rd_match_s;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock, flush-to-bubble and saturating perf counters.
module id_ex_stage
   import rv32i_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             valid_ID,
   input  logic [XLEN-1:0]  pc_ID,
   input  logic [XLEN-1:0]  rs1Data_ID,
   input  logic [XLEN-1:0]  rs2Data_ID,
   input  logic [XLEN-1:0]  imm_ID,
   input  logic [4:0]       RS1_ID,
   input  logic [4:0]       RS2_ID,
   input  logic [4:0]       RD_ID,
   input  logic             RegWEn_ID,
   input  logic             MemRead_ID,
   input  logic             MemRW_ID,
   input  logic [3:0]       ALUSel_ID,
   input  logic [1:0]       WBSel_ID,
   input  logic             flush_EX,
   output logic             valid_EX,
   output logic [XLEN-1:0]  pc_EX,
   output logic [XLEN-1:0]  rs1Data_EX,
   output logic [XLEN-1:0]  rs2Data_EX,
   output logic [XLEN-1:0]  imm_EX,
   output logic [4:0]       RS1_EX,
   output logic [4:0]       RS2_EX,
   output logic [4:0]       RD_EX,
   output logic             RegWEn_EX,
   output logic             MemRead_EX,
   output logic             MemRW_EX,
   output logic [3:0]       ALUSel_EX,
   output logic [1:0]       WBSel_EX,
   output logic             stall_IF_ID,
   output logic [CNT_W-1:0] stallCnt,
   output logic [CNT_W-1:0] flushCnt
);

   ctrl_t             ctrl_d, ctrl_q;
   logic [XLEN-1:0]   pc_d, pc_q;
   logic [XLEN-1:0]   rs1_data_d, rs1_data_q;
   logic [XLEN-1:0]   rs2_data_d, rs2_data_q;
   logic [XLEN-1:0]   imm_d, imm_q;
   logic [4:0]        rs1_d, rs1_q;
   logic [4:0]        rs2_d, rs2_q;
   logic [4:0]        rd_d, rd_q;
   logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;
   logic [CNT_W-1:0]  flush_cnt_d, flush_cnt_q;
   logic              load_use_s;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      if (&cnt) begin
         return cnt;
      end else begin
         return cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   loaduse_detect u_loaduse_detect (
      .valid_id_i    (valid_ID),
      .valid_ex_i    (ctrl_q.valid),
      .mem_read_ex_i (ctrl_q.mem_read),
      .reg_wen_ex_i  (ctrl_q.reg_wen),
      .rd_ex_i       (rd_q),
      .rs1_id_i      (RS1_ID),
      .rs2_id_i      (RS2_ID),
      .load_use_o    (load_use_s)
   );

   // A flush kills ID anyway, so freezing upstream would only waste a cycle.
   assign stall_IF_ID = load_use_s & ~flush_EX & reset_n;

   // Next-state: flush beats load-use, both insert a bubble; otherwise capture ID.
   always_comb begin
      ctrl_d      = CTRL_BUBBLE;
      pc_d        = {XLEN{1'b0}};
      rs1_data_d  = {XLEN{1'b0}};
      rs2_data_d  = {XLEN{1'b0}};
      imm_d       = {XLEN{1'b0}};
      rs1_d       = REG_X0;
      rs2_d       = REG_X0;
      rd_d        = REG_X0;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (flush_EX) begin
         flush_cnt_d = sat_inc(flush_cnt_q);
      end else if (load_use_s) begin
         stall_cnt_d = sat_inc(stall_cnt_q);
      end else begin
         ctrl_d.valid    = valid_ID;
         ctrl_d.reg_wen  = RegWEn_ID;
         ctrl_d.mem_read = MemRead_ID;
         ctrl_d.mem_rw   = MemRW_ID;
         ctrl_d.alu_sel  = ALUSel_ID;
         ctrl_d.wb_sel   = WBSel_ID;
         pc_d            = pc_ID;
         rs1_data_d      = rs1Data_ID;
         rs2_data_d      = rs2Data_ID;
         imm_d           = imm_ID;
         rs1_d           = RS1_ID;
         rs2_d           = RS2_ID;
         rd_d            = RD_ID;
      end
   end

   // Pipeline and counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q      <= CTRL_BUBBLE;
         pc_q        <= {XLEN{1'b0}};
         rs1_data_q  <= {XLEN{1'b0}};
         rs2_data_q  <= {XLEN{1'b0}};
         imm_q       <= {XLEN{1'b0}};
         rs1_q       <= REG_X0;
         rs2_q       <= REG_X0;
         rd_q        <= REG_X0;
         stall_cnt_q <= {CNT_W{1'b0}};
         flush_cnt_q <= {CNT_W{1'b0}};
      end else begin
         ctrl_q      <= ctrl_d;
         pc_q        <= pc_d;
         rs1_data_q  <= rs1_data_d;
         rs2_data_q  <= rs2_data_d;
         imm_q       <= imm_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         rd_q        <= rd_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign valid_EX   = ctrl_q.valid;
   assign RegWEn_EX  = ctrl_q.reg_wen;
   assign MemRead_EX = ctrl_q.mem_read;
   assign MemRW_EX   = ctrl_q.mem_rw;
   assign ALUSel_EX  = ctrl_q.alu_sel;
   assign WBSel_EX   = ctrl_q.wb_sel;
   assign pc_EX      = pc_q;
   assign rs1Data_EX = rs1_data_q;
   assign rs2Data_EX = rs2_data_q;
   assign imm_EX     = imm_q;
   assign RS1_EX     = rs1_q;
   assign RS2_EX     = rs2_q;
   assign RD_EX      = rd_q;
   assign stallCnt   = stall_cnt_q;
   assign flushCnt   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reference model feeds a scoreboard queue checked one cycle later.
module tb_id_ex_stage;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;

   typedef struct packed {
      logic             valid;
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  rs1d;
      logic [XLEN-1:0]  rs2d;
      logic [XLEN-1:0]  imm;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [4:0]       rd;
      logic             regwen;
      logic             memread;
      logic             memrw;
      logic [3:0]       alusel;
      logic [1:0]       wbsel;
      logic [CNT_W-1:0] scnt;
      logic [CNT_W-1:0] fcnt;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             valid_ID;
   logic [XLEN-1:0]  pc_ID, rs1Data_ID, rs2Data_ID, imm_ID;
   logic [4:0]       RS1_ID, RS2_ID, RD_ID;
   logic             RegWEn_ID, MemRead_ID, MemRW_ID;
   logic [3:0]       ALUSel_ID;
   logic [1:0]       WBSel_ID;
   logic             flush_EX;
   logic             valid_EX;
   logic [XLEN-1:0]  pc_EX, rs1Data_EX, rs2Data_EX, imm_EX;
   logic [4:0]       RS1_EX, RS2_EX, RD_EX;
   logic             RegWEn_EX, MemRead_EX, MemRW_EX;
   logic [3:0]       ALUSel_EX;
   logic [1:0]       WBSel_EX;
   logic             stall_IF_ID;
   logic [CNT_W-1:0] stallCnt, flushCnt;

   int   n_assert = 0;
   int   n_fail   = 0;
   exp_t model;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset_n(reset_n), .valid_ID(valid_ID), .pc_ID(pc_ID),
      .rs1Data_ID(rs1Data_ID), .rs2Data_ID(rs2Data_ID), .imm_ID(imm_ID),
      .RS1_ID(RS1_ID), .RS2_ID(RS2_ID), .RD_ID(RD_ID), .RegWEn_ID(RegWEn_ID),
      .MemRead_ID(MemRead_ID), .MemRW_ID(MemRW_ID), .ALUSel_ID(ALUSel_ID),
      .WBSel_ID(WBSel_ID), .flush_EX(flush_EX), .valid_EX(valid_EX), .pc_EX(pc_EX),
      .rs1Data_EX(rs1Data_EX), .rs2Data_EX(rs2Data_EX), .imm_EX(imm_EX),
      .RS1_EX(RS1_EX), .RS2_EX(RS2_EX), .RD_EX(RD_EX), .RegWEn_EX(RegWEn_EX),
      .MemRead_EX(MemRead_EX), .MemRW_EX(MemRW_EX), .ALUSel_EX(ALUSel_EX),
      .WBSel_EX(WBSel_EX), .stall_IF_ID(stall_IF_ID), .stallCnt(stallCnt),
      .flushCnt(flushCnt)
   );

   task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [CNT_W-1:0] m_inc(input logic [CNT_W-1:0] c);
      return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
   endfunction

   task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic wen,
                        input logic mrd, input logic mwr, input logic [3:0] alu,
                        input logic [1:0] wb, input logic fl);
      valid_ID = v; pc_ID = pc; RS1_ID = rs1; RS2_ID = rs2; RD_ID = rd;
      RegWEn_ID = wen; MemRead_ID = mrd; MemRW_ID = mwr; ALUSel_ID = alu; WBSel_ID = wb;
      flush_EX = fl;
      rs1Data_ID = 32'h1000_0000 | {27'd0, rs1};
      rs2Data_ID = 32'h2000_0000 | {27'd0, rs2};
      imm_ID     = pc ^ 32'h0000_0F0F;
   endtask

   function automatic logic m_load_use();
      return valid_ID & model.valid & model.memread & model.regwen & (model.rd != 5'd0)
             & ((model.rd == RS1_ID) | (model.rd == RS2_ID));
   endfunction

   function automatic void m_clear();
      model = '0;
   endfunction

   // One clock: check combinational stall, predict EX state, compare after the edge.
   task automatic step(input string tag);
      logic lu;
      exp_t e;
      @(negedge clk);
      lu = m_load_use();
      chk({tag, ".stall"}, {31'd0, stall_IF_ID}, {31'd0, lu & ~flush_EX});
      e = model;
      if (flush_EX) begin
         e = '0; e.scnt = model.scnt; e.fcnt = m_inc(model.fcnt);
      end else if (lu) begin
         e = '0; e.fcnt = model.fcnt; e.scnt = m_inc(model.scnt);
      end else begin
         e.valid = valid_ID; e.pc = pc_ID; e.rs1d = rs1Data_ID; e.rs2d = rs2Data_ID;
         e.imm = imm_ID; e.rs1 = RS1_ID; e.rs2 = RS2_ID; e.rd = RD_ID; e.regwen = RegWEn_ID;
         e.memread = MemRead_ID; e.memrw = MemRW_ID; e.alusel = ALUSel_ID; e.wbsel = WBSel_ID;
      end
      model = e;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk({tag, ".valid"},  {31'd0, valid_EX}, {31'd0, e.valid});
      chk({tag, ".pc"},     pc_EX, e.pc);
      chk({tag, ".rs1d"},   rs1Data_EX, e.rs1d);
      chk({tag, ".rs2d"},   rs2Data_EX, e.rs2d);
      chk({tag, ".imm"},    imm_EX, e.imm);
      chk({tag, ".idx"},    {17'd0, RS1_EX, RS2_EX, RD_EX}, {17'd0, e.rs1, e.rs2, e.rd});
      chk({tag, ".ctrl"},   {23'd0, RegWEn_EX, MemRead_EX, MemRW_EX, ALUSel_EX, WBSel_EX},
                            {23'd0, e.regwen, e.memread, e.memrw, e.alusel, e.wbsel});
      chk({tag, ".cnt"},    {24'd0, stallCnt, flushCnt}, {24'd0, e.scnt, e.fcnt});
   endtask

   initial begin
      // 1. Reset with random ID inputs
      reset_n = 1'b0;
      drive(1'b1, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b0,
            4'($urandom), 2'($urandom), 1'b0);
      m_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("reset.valid", {31'd0, valid_EX}, 32'd0);
      chk("reset.pc", pc_EX, 32'd0);
      chk("reset.data", rs1Data_EX | rs2Data_EX | imm_EX, 32'd0);
      chk("reset.idx", {17'd0, RS1_EX, RS2_EX, RD_EX}, 32'd0);
      chk("reset.ctrl", {23'd0, RegWEn_EX, MemRead_EX, MemRW_EX, ALUSel_EX, WBSel_EX}, 32'd0);
      chk("reset.cnt", {24'd0, stallCnt, flushCnt}, 32'd0);
      chk("reset.stall", {31'd0, stall_IF_ID}, 32'd0);
      reset_n = 1'b1;
      step("release");
      chk("release.pc", pc_EX, pc_ID);

      // 2. Pass-through ADD x3,x1,x2
      drive(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 4'd0, 2'd1, 1'b0);
      step("add");
      chk("add.direct", {pc_EX[15:0], 1'b0, RS1_EX, RS2_EX, RD_EX}, {16'h0100, 1'b0, 5'd1, 5'd2, 5'd3});

      // 3. Load-use: LW x5 then ADD x6,x5,x1
      drive(1'b1, 32'h104, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 1'b0);
      step("lw5");
      drive(1'b1, 32'h108, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 4'd0, 2'd1, 1'b0);
      step("lu.bubble");
      chk("lu.bubble_valid", {31'd0, valid_EX}, 32'd0);
      chk("lu.stallcnt", {28'd0, stallCnt}, 32'd1);
      step("lu.reissue");
      chk("lu.rs1", {27'd0, RS1_EX}, 32'd5);

      // 4. LW x0 followed by reader of x0
      drive(1'b1, 32'h10C, 5'd2, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 1'b0);
      step("lw0");
      drive(1'b1, 32'h110, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 4'd1, 2'd1, 1'b0);
      step("x0.nostall");
      chk("x0.valid", {31'd0, valid_EX}, 32'd1);

      // 5. Flush together with a load-use
      drive(1'b1, 32'h114, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 1'b0);
      step("lw5b");
      drive(1'b1, 32'h118, 5'd1, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 4'd0, 2'd1, 1'b1);
      step("flush");
      chk("flush.counts", {24'd0, stallCnt, flushCnt}, {24'd0, 4'd1, 4'd1});

      // Async reset in the middle of a stall
      drive(1'b1, 32'h11C, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 1'b0);
      step("lw5c");
      drive(1'b1, 32'h120, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 4'd0, 2'd1, 1'b0);
      @(negedge clk);
      chk("midrst.pre_stall", {31'd0, stall_IF_ID}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("midrst.stall", {31'd0, stall_IF_ID}, 32'd0);
      chk("midrst.state", {26'd0, valid_EX, MemRead_EX, RD_EX}, 32'd0);
      chk("midrst.cnt", {24'd0, stallCnt, flushCnt}, 32'd0);
      m_clear();
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // 6. Saturation: 19 load-use stalls on a 4-bit counter
      for (int i = 0; i < 19; i++) begin
         drive(1'b1, 32'h200 + 32'(i * 8), 5'd1, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 1'b0);
         step("sat.lw");
         drive(1'b1, 32'h204 + 32'(i * 8), 5'd3, 5'd9, 5'd4, 1'b1, 1'b0, 1'b0, 4'd0, 2'd1, 1'b0);
         step("sat.use");
      end
      chk("sat.stallcnt", {28'd0, stallCnt}, 32'hF);
      chk("sat.flushcnt", {28'd0, flushCnt}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
